// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and small PC helpers.
package riscv_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // Instructions are word aligned; the low two address bits are always zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_entry_buffer.sv
// In-order fetch queue storage. Entries are allocated at the tail when a
// request is granted, filled in allocation order as responses return, and
// retired from the head once filled. A flush empties the queue in one cycle.
module fetch_entry_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_flush,
  input  logic                         i_alloc,
  input  logic [XLEN-1:0]              i_alloc_pc,
  input  logic                         i_fill,
  input  logic [XLEN-1:0]              i_fill_inst,
  input  logic                         i_deq,
  output logic                         o_head_valid,
  output logic [XLEN-1:0]              o_head_pc,
  output logic [XLEN-1:0]              o_head_inst,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_unfilled
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] r_pc     [DEPTH];
  logic [XLEN-1:0] r_inst   [DEPTH];
  logic            r_filled [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [PW-1:0]   r_fill;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_unfilled;

  // Pointer, occupancy and per-entry updates; flush drops every entry at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]     <= '0;
        r_inst[i]   <= '0;
        r_filled[i] <= 1'b0;
      end
    end else if (i_flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_filled[i] <= 1'b0;
      end
    end else begin
      if (i_alloc) begin
        r_pc[r_tail]     <= i_alloc_pc;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + PW'(1);
      end
      // The fill slot is always an already-allocated entry, never the new tail.
      if (i_fill) begin
        r_inst[r_fill]   <= i_fill_inst;
        r_filled[r_fill] <= 1'b1;
        r_fill           <= r_fill + PW'(1);
      end
      if (i_deq) begin
        r_head <= r_head + PW'(1);
      end
      r_count    <= r_count + CW'(i_alloc) - CW'(i_deq);
      r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
    end
  end

  assign o_head_valid = (r_count != '0) & r_filled[r_head];
  assign o_head_pc    = r_pc[r_head];
  assign o_head_inst  = r_inst[r_head];
  assign o_count      = r_count;
  assign o_unfilled   = r_unfilled;

endmodule

// File: rtl/fetch_queue_unit_checker.sv
// Protocol checks for the instruction-memory interface of the fetch unit.
module fetch_queue_unit_checker #(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_rvalid,
  input  logic [CW-1:0] i_outstanding
);

  a_rvalid_needs_outstanding: assert property (
    @(posedge clock) disable iff (reset) i_rvalid |-> (i_outstanding != '0)
  );

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests
// to instruction memory, tracks responses that must be discarded after a
// redirect, and presents the oldest returned instruction to IF/ID.
module fetch_queue_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_pc_add4,
  output logic [XLEN-1:0] o_if_inst
);

  localparam int            CW  = $clog2(DEPTH+1);
  localparam logic [CW:0]   CAP = (CW+1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_unfilled;
  logic [CW-1:0]   w_outstanding;
  logic [CW:0]     w_occupancy;
  logic [CW-1:0]   w_drop_next;
  logic            w_req;
  logic            w_alloc;
  logic            w_fill;
  logic            w_deq;
  logic            w_head_valid;
  logic [XLEN-1:0] w_head_pc;
  logic [XLEN-1:0] w_head_inst;

  // Discarded responses still occupy memory slots, so they count against capacity.
  assign w_occupancy   = {1'b0, w_count} + {1'b0, r_drop_cnt};
  assign w_outstanding = w_unfilled + r_drop_cnt;
  assign w_req         = !i_redirect_valid & (w_occupancy < CAP);
  assign w_alloc       = w_req & i_imem_gnt;
  assign w_fill        = i_imem_rvalid & !i_redirect_valid & (r_drop_cnt == '0) & (w_unfilled != '0);
  assign w_deq         = w_head_valid & i_if_ready & !i_redirect_valid;

  // Next discard count: a redirect turns every unfilled slot into a stale response.
  always_comb begin
    w_drop_next = r_drop_cnt;
    if (i_redirect_valid) begin
      if (i_imem_rvalid && (w_outstanding != '0)) begin
        w_drop_next = w_outstanding - CW'(1);
      end else begin
        w_drop_next = w_outstanding;
      end
    end else if (i_imem_rvalid && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - CW'(1);
    end else begin
      w_drop_next = r_drop_cnt;
    end
  end

  // Fetch PC and discard counter; redirect takes priority over sequential advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_next;
      if (i_redirect_valid) begin
        r_fetch_pc <= align_pc(i_redirect_pc);
      end else if (w_alloc) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end
    end
  end

  fetch_entry_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clock        (clock),
    .reset        (reset),
    .i_flush      (i_redirect_valid),
    .i_alloc      (w_alloc),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill       (w_fill),
    .i_fill_inst  (i_imem_rdata),
    .i_deq        (w_deq),
    .o_head_valid (w_head_valid),
    .o_head_pc    (w_head_pc),
    .o_head_inst  (w_head_inst),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled)
  );

  fetch_queue_unit_checker #(
    .CW (CW)
  ) u_checker (
    .clock         (clock),
    .reset         (reset),
    .i_rvalid      (i_imem_rvalid),
    .i_outstanding (w_outstanding)
  );

  // Requests are suppressed while reset is held so the interface is quiet.
  assign o_imem_req   = w_req & !reset;
  assign o_imem_addr  = r_fetch_pc;
  assign o_if_valid   = w_head_valid;
  assign o_if_pc      = w_head_pc;
  assign o_if_pc_add4 = w_head_valid ? (w_head_pc + PC_STEP) : '0;
  assign o_if_inst    = w_head_inst;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: a queue-level reference model
// plus an in-order fixed-latency memory, checked every cycle, with literal
// expectations for the directed scenarios.
module tb_fetch_queue_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_pc_add4;
  logic [31:0] if_inst;

  always #5 clock = ~clock;

  fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock            (clock),
    .reset            (reset),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_gnt       (imem_gnt),
    .i_imem_rvalid    (imem_rvalid),
    .i_imem_rdata     (imem_rdata),
    .o_if_valid       (if_valid),
    .i_if_ready       (if_ready),
    .o_if_pc          (if_pc),
    .o_if_pc_add4     (if_pc_add4),
    .o_if_inst        (if_inst)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; bit filled; } ent_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  ent_t        m_q[$];
  int          m_drop;
  logic [31:0] m_fetch_pc;
  pend_t       mem_q[$];
  int          mem_lat = 1;
  int          cyc;
  int          grants;
  int          first_valid_cyc;
  logic [31:0] first_valid_pc;
  logic [31:0] first_valid_add4;
  logic [31:0] deq_log[$];
  bit          cap_grant;
  logic [31:0] cap_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic bit exp_req();
    return !redirect_valid && ((m_q.size() + m_drop) < 4);
  endfunction

  function automatic bit exp_valid();
    return (m_q.size() > 0) && m_q[0].filled;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (deq_log.size() > i) ? deq_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("imem_req", 32'(imem_req), 32'(exp_req()));
    if (exp_req()) chk("imem_addr", imem_addr, m_fetch_pc);
    chk("if_valid", 32'(if_valid), 32'(exp_valid()));
    if (exp_valid()) begin
      chk("if_pc", if_pc, m_q[0].pc);
      chk("if_pc_add4", if_pc_add4, m_q[0].pc + 32'd4);
      chk("if_inst", if_inst, m_q[0].inst);
    end
    if (imem_req && imem_gnt) grants++;
    if (if_valid && first_valid_cyc < 0) begin
      first_valid_cyc  = cyc;
      first_valid_pc   = if_pc;
      first_valid_add4 = if_pc_add4;
    end
    if (if_valid && if_ready && !redirect_valid) deq_log.push_back(if_pc);
  endtask

  task automatic model_step();
    bit grant;
    bit deq;
    int unf;
    grant = exp_req() && imem_gnt;
    deq   = exp_valid() && if_ready && !redirect_valid;
    unf   = 0;
    foreach (m_q[i]) if (!m_q[i].filled) unf++;
    if (redirect_valid) begin
      m_drop = m_drop + unf - ((imem_rvalid && (m_drop + unf) > 0) ? 1 : 0);
      m_q.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (imem_rvalid) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          for (int i = 0; i < m_q.size(); i++) begin
            if (!m_q[i].filled) begin
              m_q[i].inst   = imem_rdata;
              m_q[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (deq) void'(m_q.pop_front());
      if (grant) begin
        m_q.push_back('{pc: m_fetch_pc, inst: 32'h0, filled: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic mem_drive();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic tick();
    #3;
    compare();
    cap_grant = imem_req && imem_gnt;
    cap_addr  = imem_addr;
    @(posedge clock);
    model_step();
    if (imem_rvalid) void'(mem_q.pop_front());
    if (cap_grant) mem_q.push_back('{addr: cap_addr, due: cyc + mem_lat});
    cyc++;
    #1;
    mem_drive();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    #2;
    chk({tag, "_rst_req"},   32'(imem_req), 32'h0);
    chk({tag, "_rst_addr"},  imem_addr,     32'h0);
    chk({tag, "_rst_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_rst_pc"},    if_pc,         32'h0);
    chk({tag, "_rst_add4"},  if_pc_add4,    32'h0);
    chk({tag, "_rst_inst"},  if_inst,       32'h0);
    m_q.delete();
    m_drop = 0;
    m_fetch_pc = 32'h0;
    mem_q.delete();
    grants = 0;
    first_valid_cyc = -1;
    first_valid_pc = 32'h0;
    first_valid_add4 = 32'h0;
    deq_log.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1;
    // 1: zero-wait memory, always ready
    do_reset("t1");
    mem_lat = 1; imem_gnt = 1'b1; if_ready = 1'b1;
    repeat (8) tick();
    chk("t1_first_valid_cyc", first_valid_cyc, 32'd2);
    chk("t1_deq0", log_at(0), 32'h0);
    chk("t1_deq1", log_at(1), 32'h4);
    chk("t1_deq2", log_at(2), 32'h8);
    chk("t1_deq3", log_at(3), 32'hC);
    chk("t1_deq_count", deq_log.size(), 32'd6);

    // 2: consumer stalled, queue fills to DEPTH and stops requesting
    do_reset("t2");
    mem_lat = 1; imem_gnt = 1'b1; if_ready = 1'b0;
    repeat (10) tick();
    chk("t2_grants", grants, 32'd4);
    chk("t2_req_low", 32'(imem_req), 32'h0);
    if_ready = 1'b1;
    repeat (6) tick();
    chk("t2_deq0", log_at(0), 32'h0);
    chk("t2_deq1", log_at(1), 32'h4);
    chk("t2_deq2", log_at(2), 32'h8);
    chk("t2_deq3", log_at(3), 32'hC);

    // 3: redirect with two requests in flight, latency 3
    do_reset("t3");
    mem_lat = 3; imem_gnt = 1'b1; if_ready = 1'b1;
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_model_drop", m_drop, 32'd2);
    chk("t3_dut_drop", 32'(dut.r_drop_cnt), 32'd2);
    repeat (6) tick();
    chk("t3_first_valid_cyc", first_valid_cyc, 32'd7);
    chk("t3_first_pc", first_valid_pc, 32'h100);
    chk("t3_first_add4", first_valid_add4, 32'h104);

    // 4: redirect coinciding with rvalid and a ready head
    do_reset("t4");
    mem_lat = 1; imem_gnt = 1'b1; if_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t4_valid_after", 32'(if_valid), 32'h0);
    chk("t4_dut_drop", 32'(dut.r_drop_cnt), 32'd0);
    chk("t4_deq_count", deq_log.size(), 32'd1);
    repeat (4) tick();
    chk("t4_next_deq", log_at(1), 32'h40);

    // 5: PC alignment and 32-bit wrap
    do_reset("t5");
    mem_lat = 1; imem_gnt = 1'b0; if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect_valid = 1'b0;
    chk("t5_aligned_addr", imem_addr, 32'h200);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap_addr", imem_addr, 32'h0);
    repeat (4) tick();
    chk("t5_wrap_deq", log_at(0), 32'hFFFF_FFFC);
    chk("t5_wrap_add4", first_valid_add4, 32'h0);

    // 6: reset while three entries are held and one response is pending discard
    do_reset("t6a");
    mem_lat = 10; imem_gnt = 1'b1; if_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    chk("t6_model_entries", m_q.size(), 32'd3);
    chk("t6_model_drop", m_drop, 32'd1);
    chk("t6_dut_drop", 32'(dut.r_drop_cnt), 32'd1);
    chk("t6_req_full", 32'(imem_req), 32'h0);
    do_reset("t6b");
    mem_lat = 1; imem_gnt = 1'b1; if_ready = 1'b1;
    #1;
    chk("t6_req_after", 32'(imem_req), 32'h1);
    chk("t6_addr_after", imem_addr, 32'h0);
    #(-1 + 1);
    repeat (4) tick();
    chk("t6_deq0", log_at(0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
